conv_line_buffer: RTL and testbench
===================================

Name: conv_line_buffer

Overview:
- Upstream neighbour of the PE: converts a raster-order pixel stream (one 8-bit activation per cycle) into 3-row vertical columns on the PE's 24-bit image_in bus.
- The PE's internal image buffer then assembles three consecutive columns into the 3x3 window.
- Holds the two previous image rows in on-chip row memories and tracks row/column position.
- Flags when a column, and when a full 3x3 window, is valid.

Parameters:
- PIX_W, 8: bits per pixel.
- IMG_W, 32: pixels per row. Must be at least 3.
- IMG_H, 32: rows per frame. Must be at least 3.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- pix_valid  input  1  pix_in carries a pixel this cycle.
- pix_in  input  PIX_W  pixel, raster order.
- sof  input  1  qualified by pix_valid; the current pixel is (row 0, col 0).
- col_out  output  3*PIX_W  [7:0] = row r, [15:8] = row r-1, [23:16] = row r-2, all at column c.
- col_valid  output  1  col_out holds a complete column (r >= 2).
- win_valid  output  1  col_valid and c >= 2; the PE's image buffer holds a full 3x3 window.
- row_idx  output  clog2(IMG_H)  row of the pixel reflected in col_out.
- col_idx  output  clog2(IMG_W)  column of the pixel reflected in col_out.
- frame_done  output  1  one-cycle pulse, same cycle as the column for pixel (IMG_H-1, IMG_W-1).

Behaviour:
- Reset (rst low, async):
  - col_out = 0; col_valid, win_valid and frame_done = 0; row_idx and col_idx = 0.
  - Internal counters r and c = 0.
  - Row memories are not reset. Their contents are don't-care until overwritten; the valid gating covers this.
- Accepted pixel: a cycle with pix_valid = 1. With pix_valid = 0, counters, memories, col_out and the indices hold, and all three flags are 0.
- Memories: lb0 holds row r-1, lb1 holds row r-2, each IMG_W x PIX_W. On an accepted pixel at (r, c):
  - Read lb0[c] and lb1[c].
  - Write lb1[c] <= old lb0[c], and lb0[c] <= pix_in. Read-before-write at the same address.
- Latency: 1 cycle. On the clock edge after acceptance:
  - col_out <= {lb1[c], lb0[c], pix_in}.
  - row_idx <= r, col_idx <= c.
  - col_valid <= (r >= 2).
  - win_valid <= (r >= 2) and (c >= 2).
  - frame_done <= (r == IMG_H-1) and (c == IMG_W-1).
- Counter update per accepted pixel:
  - c increments.
  - At c == IMG_W-1: c wraps to 0 and r increments.
  - At r == IMG_H-1 and c == IMG_W-1: r and c both wrap to 0, so the next frame starts without sof.
- sof with pix_valid: the pixel is processed as (0, 0), overriding the counters.
  - col_valid and win_valid = 0 for that pixel.
  - Counters continue from (0, 1).
  - Stale row-memory data is not cleared; the r >= 2 gating hides it.
- sof without pix_valid: ignored.
- Gaps: any number of idle cycles between pixels, including mid-row and at row boundaries. Results are identical to the gap-free stream.
- Window semantics: win_valid on the column at (r, c) means rows r-2..r and columns c-2..c are resident in the PE. Columns at c = 0 and c = 1 of each row are flagged col_valid only, with no wrap across rows.
- Reset mid-frame: all outputs and counters return to reset values. The next accepted pixel is (0, 0) regardless of sof.

Decomposition:
- Package conv_pkg:
  - PIX_W.
  - Column slice constants: COL_NEW_LSB = 0, COL_R1_LSB = PIX_W, COL_R2_LSB = 2*PIX_W.
  - Shared with the PE-side window logic.
- Sub-module line_mem:
  - One IMG_W x PIX_W row memory, single clock.
  - Synchronous write; combinational read at the same address with read-before-write.
  - Instantiated twice: lb0 and lb1.
- Counters, flag logic and output register stay in the top module.

Test Plan:
- Setup for all scenarios: IMG_W = 4, IMG_H = 4, pixel = r*16 + c. Stream one frame, sof on the first pixel, no gaps.
- Rows 0-1 -> col_valid = 0 throughout. Pixel (2,0) -> next cycle col_out = 24'h001020, col_valid = 1, win_valid = 0.
- Pixel (2,2) -> col_out = 24'h021222, win_valid = 1. Pixel (3,3) -> col_out = 24'h132333, win_valid = 1, frame_done = 1 for exactly one cycle.
- Repeat the frame with 1-3 random idle cycles between pixels -> identical col_out/flag sequence on valid cycles; all flags 0 on idle cycles.
- Second frame without sof -> wraps to (0,0); col_valid first rises again at (2,0). Assert sof at pixel (1,2) of that frame -> that pixel is reported as row_idx = 0, col_idx = 0, col_valid = 0.
- Drive rst low at pixel (2,1) -> outputs 0 immediately (async). After release, the next pixel is reported as (0,0), and col_valid stays 0 until two further full rows are streamed.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared pixel width and column-bus slice positions used by the line buffer
// and by the PE-side window logic.
package conv_pkg;
   localparam int PIX_W       = 8;
   localparam int COL_NEW_LSB = 0;
   localparam int COL_R1_LSB  = PIX_W;
   localparam int COL_R2_LSB  = 2 * PIX_W;
endpackage

// File: rtl/line_mem.sv
// One image row of pixels: synchronous write, combinational read at the same
// address, so a read in the write cycle returns the value being replaced.
module line_mem #(
   parameter int PIX_W = 8,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [PIX_W-1:0] wdata_i,
   output logic [PIX_W-1:0] rdata_o
);

   logic [PIX_W-1:0] mem_q [DEPTH];

   // No reset: contents are only trusted once the row gating says so.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/conv_line_buffer.sv
// Turns a raster pixel stream into 3-row vertical columns for the PE, with
// row/column position tracking and column/window/frame flags.
module conv_line_buffer #(
   parameter int PIX_W = conv_pkg::PIX_W,
   parameter int IMG_W = 32,
   parameter int IMG_H = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pix_valid,
   input  logic [PIX_W-1:0]         pix_in,
   input  logic                     sof,
   output logic [3*PIX_W-1:0]       col_out,
   output logic                     col_valid,
   output logic                     win_valid,
   output logic [$clog2(IMG_H)-1:0] row_idx,
   output logic [$clog2(IMG_W)-1:0] col_idx,
   output logic                     frame_done
);
   import conv_pkg::*;

   localparam int RW = $clog2(IMG_H);
   localparam int CW = $clog2(IMG_W);
   localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] R_TWO  = RW'(2);
   localparam logic [CW-1:0] C_TWO  = CW'(2);

   logic [RW-1:0]    r_q, r_d, cur_r;
   logic [CW-1:0]    c_q, c_d, cur_c;
   logic [PIX_W-1:0] lb0_rd, lb1_rd;

   // sof overrides the tracked position for the pixel it accompanies.
   always_comb begin
      cur_r = sof ? '0 : r_q;
      cur_c = sof ? '0 : c_q;
      r_d   = r_q;
      c_d   = c_q;
      if (pix_valid) begin
         if (cur_c == C_LAST) begin
            c_d = '0;
            r_d = (cur_r == R_LAST) ? '0 : cur_r + RW'(1);
         end else begin
            c_d = cur_c + CW'(1);
            r_d = cur_r;
         end
      end
   end

   line_mem #(.PIX_W(PIX_W), .DEPTH(IMG_W), .AW(CW)) u_lb0 (
      .clk     (clk),
      .we_i    (pix_valid),
      .addr_i  (cur_c),
      .wdata_i (pix_in),
      .rdata_o (lb0_rd)
   );

   // Row r-1 ages into row r-2 as the new pixel replaces it.
   line_mem #(.PIX_W(PIX_W), .DEPTH(IMG_W), .AW(CW)) u_lb1 (
      .clk     (clk),
      .we_i    (pix_valid),
      .addr_i  (cur_c),
      .wdata_i (lb0_rd),
      .rdata_o (lb1_rd)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q        <= '0;
         c_q        <= '0;
         col_out    <= '0;
         col_valid  <= 1'b0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         row_idx    <= '0;
         col_idx    <= '0;
      end else begin
         r_q <= r_d;
         c_q <= c_d;
         if (pix_valid) begin
            col_out[COL_NEW_LSB +: PIX_W] <= pix_in;
            col_out[COL_R1_LSB  +: PIX_W] <= lb0_rd;
            col_out[COL_R2_LSB  +: PIX_W] <= lb1_rd;
            row_idx    <= cur_r;
            col_idx    <= cur_c;
            col_valid  <= (cur_r >= R_TWO);
            win_valid  <= (cur_r >= R_TWO) && (cur_c >= C_TWO);
            frame_done <= (cur_r == R_LAST) && (cur_c == C_LAST);
         end else begin
            col_valid  <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv_line_buffer.sv
// Randomized bench for conv_line_buffer on a 4x4 image, checked against a
// per-column pixel-history model of the raster stream.
module tb_conv_line_buffer;
   localparam int W = 4;
   localparam int H = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pix_valid = 1'b0;
   logic [7:0]  pix_in = '0;
   logic        sof = 1'b0;
   logic [23:0] col_out;
   logic        col_valid, win_valid, frame_done;
   logic [1:0]  row_idx, col_idx;

   conv_line_buffer #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_valid  (pix_valid),
      .pix_in     (pix_in),
      .sof        (sof),
      .col_out    (col_out),
      .col_valid  (col_valid),
      .win_valid  (win_valid),
      .row_idx    (row_idx),
      .col_idx    (col_idx),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: position in the frame plus the last two pixels seen per column.
   int          mr = 0, mc = 0;
   logic [7:0]  h1 [W];
   logic [7:0]  h2 [W];
   logic [23:0] exp_q [$];
   logic [23:0] last_col = '0;
   logic        last_known = 1'b1;
   int          last_r = 0, last_c = 0;
   logic        e_cv, e_wv, e_fd;
   int          e_r, e_c;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle();
      check_eq("idle_col_valid", 32'(col_valid), 32'd0);
      check_eq("idle_win_valid", 32'(win_valid), 32'd0);
      check_eq("idle_frame_done", 32'(frame_done), 32'd0);
      check_eq("idle_row_idx", 32'(row_idx), 32'(last_r));
      check_eq("idle_col_idx", 32'(col_idx), 32'(last_c));
      if (last_known) check_eq("idle_col_out", 32'(col_out), 32'(last_col));
      else            check_eq("idle_col_new", 32'(col_out[7:0]), 32'(last_col[7:0]));
   endtask

   task automatic check_accept();
      logic [23:0] e;
      e = exp_q.pop_front();
      if (e_cv) check_eq("col_out", 32'(col_out), 32'(e));
      else      check_eq("col_new", 32'(col_out[7:0]), 32'(e[7:0]));
      check_eq("col_valid", 32'(col_valid), 32'(e_cv));
      check_eq("win_valid", 32'(win_valid), 32'(e_wv));
      check_eq("frame_done", 32'(frame_done), 32'(e_fd));
      check_eq("row_idx", 32'(row_idx), 32'(e_r));
      check_eq("col_idx", 32'(col_idx), 32'(e_c));
      last_col = e; last_known = e_cv; last_r = e_r; last_c = e_c;
   endtask

   task automatic send(input logic [7:0] p, input logic s, input int idle, input logic idle_sof);
      int pos;
      repeat (idle) begin
         pix_valid = 1'b0;
         sof = idle_sof;
         @(posedge clk); #1;
         check_idle();
      end
      if (s) begin mr = 0; mc = 0; end
      exp_q.push_back({h2[mc], h1[mc], p});
      e_cv = (mr >= 2);
      e_wv = (mr >= 2) && (mc >= 2);
      e_fd = (mr == H - 1) && (mc == W - 1);
      e_r  = mr;
      e_c  = mc;
      h2[mc] = h1[mc];
      h1[mc] = p;
      pos = (mr * W + mc + 1) % (W * H);
      mr = pos / W;
      mc = pos % W;
      pix_valid = 1'b1; pix_in = p; sof = s;
      @(posedge clk); #1;
      pix_valid = 1'b0; sof = 1'b0;
      check_accept();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_col_out"}, 32'(col_out), 32'd0);
      check_eq({tag, "_col_valid"}, 32'(col_valid), 32'd0);
      check_eq({tag, "_win_valid"}, 32'(win_valid), 32'd0);
      check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      check_eq({tag, "_row_idx"}, 32'(row_idx), 32'd0);
      check_eq({tag, "_col_idx"}, 32'(col_idx), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < W; i++) begin h1[i] = '0; h2[i] = '0; end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst = 1'b1;
      @(posedge clk); #1;
      check_idle();

      // Frame A: gap-free, sof on first pixel, pixel = r*16 + c
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            send(8'(r * 16 + c), (r == 0 && c == 0), 0, 1'b0);
            if (r == 2 && c == 0) check_eq("tp_2_0", 32'(col_out), 32'h001020);
            if (r == 2 && c == 2) check_eq("tp_2_2", 32'(col_out), 32'h021222);
            if (r == 3 && c == 3) check_eq("tp_3_3", 32'(col_out), 32'h132333);
         end
      end

      // Frame A again with random idle gaps, stray sof on idle cycles
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            send(8'(r * 16 + c), (r == 0 && c == 0), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      pix_valid = 1'b0; sof = 1'b0;
      @(posedge clk); #1;
      check_idle();

      // Frame B without sof, sof forced at pixel (1,2)
      for (int i = 0; i < 24; i++) begin
         send(8'($urandom_range(0, 255)), (i == 6), $urandom_range(0, 1), 1'b0);
         if (i == 6) begin
            check_eq("sof_row_idx", 32'(row_idx), 32'd0);
            check_eq("sof_col_idx", 32'(col_idx), 32'd0);
            check_eq("sof_col_valid", 32'(col_valid), 32'd0);
         end
      end

      // Reset mid-frame at pixel (2,1)
      for (int i = 0; i < 9; i++) send(8'($urandom_range(0, 255)), (i == 0), 0, 1'b0);
      pix_valid = 1'b1; pix_in = 8'h21;
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(posedge clk); #1;
      pix_valid = 1'b0;
      check_reset_outputs("held_rst");
      rst = 1'b1;
      mr = 0; mc = 0; last_col = '0; last_known = 1'b1; last_r = 0; last_c = 0;
      for (int i = 0; i < 20; i++) begin
         send(8'($urandom_range(0, 255)), 1'b0, 0, 1'b0);
         if (i == 0) begin
            check_eq("post_rst_row", 32'(row_idx), 32'd0);
            check_eq("post_rst_col", 32'(col_idx), 32'd0);
         end
      end

      // Long random stream: gaps, occasional sof
      for (int i = 0; i < 150; i++)
         send(8'($urandom_range(0, 255)), ($urandom_range(0, 19) == 0),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
